// File: rtl/icache_ctrl_if.sv
`default_nettype none
// ============================================================================
// icache_ctrl_if : CPU fetch, tag/data RAM and memory refill signal bundle
// Rev 1.0
// ============================================================================
interface icache_ctrl_if #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  parameter int DATA_W   = 32
);
  logic                CpuReq;
  logic [ADDR_W-1:0]   CpuAddr;
  logic                CpuReady;
  logic                CpuAck;
  logic [DATA_W-1:0]   CpuRdata;
  logic                Flush;
  logic [INDEX_W-1:0]  TagAddr;
  logic [TAG_W-1:0]    TagIn;
  logic                TagWrite;
  logic [TAG_W-1:0]    TagOut;
  logic [INDEX_W-1:0]  DataAddr;
  logic [DATA_W-1:0]   DataIn;
  logic                DataWrite;
  logic [DATA_W-1:0]   DataOut;
  logic                MemReq;
  logic [ADDR_W-1:0]   MemAddr;
  logic                MemAck;
  logic [DATA_W-1:0]   MemRdata;
  logic [15:0]         HitCnt;
  logic [15:0]         MissCnt;

  modport master (
    input  CpuReq, CpuAddr, Flush, TagOut, DataOut, MemAck, MemRdata,
    output CpuReady, CpuAck, CpuRdata, TagAddr, TagIn, TagWrite,
           DataAddr, DataIn, DataWrite, MemReq, MemAddr, HitCnt, MissCnt
  );

  modport slave (
    output CpuReq, CpuAddr, Flush, TagOut, DataOut, MemAck, MemRdata,
    input  CpuReady, CpuAck, CpuRdata, TagAddr, TagIn, TagWrite,
           DataAddr, DataIn, DataWrite, MemReq, MemAddr, HitCnt, MissCnt
  );
endinterface
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// icache_ctrl : direct-mapped read-only instruction cache controller
// Rev 1.0
// ============================================================================
module icache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  parameter int DATA_W   = 32
) (
  input  logic         Clk,
  input  logic         Rst,
  icache_ctrl_if.master bus
);
  localparam int LINES = 2 ** INDEX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_MEM    = 2'd2;
  localparam logic [1:0] S_FILL   = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [DATA_W-1:0]  fill_data;
  logic [DATA_W-1:0]  rdata_q;
  logic [15:0]        hit_cnt;
  logic [15:0]        miss_cnt;
  logic [INDEX_W-1:0] ram_idx;

  wire [INDEX_W-1:0] cpu_idx       = bus.CpuAddr[OFFSET_W +: INDEX_W];
  wire [TAG_W-1:0]   cpu_tag       = bus.CpuAddr[ADDR_W-1 -: TAG_W];
  wire               unused_offset = ^bus.CpuAddr[OFFSET_W-1:0];
  wire               accept        = (state == S_IDLE) && bus.CpuReq && !bus.Flush;
  wire               hit           = valid[idx_q] && (bus.TagOut == tag_q);

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.CpuReq && !bus.Flush) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = hit ? S_IDLE : S_MEM;
      S_MEM:    if (bus.MemAck) state_nxt = S_FILL;
      S_FILL:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // In IDLE the RAM index comes straight from the CPU so the read is registered at the accept edge.
  always_comb begin
    ram_idx       = idx_q;
    bus.CpuReady  = 1'b0;
    bus.CpuAck    = 1'b0;
    bus.CpuRdata  = rdata_q;
    bus.TagWrite  = 1'b0;
    bus.DataWrite = 1'b0;
    bus.MemReq    = 1'b0;
    case (state)
      S_IDLE: begin
        ram_idx      = cpu_idx;
        bus.CpuReady = !bus.Flush;
      end
      S_LOOKUP: begin
        if (hit) begin
          bus.CpuAck   = 1'b1;
          bus.CpuRdata = bus.DataOut;
        end
      end
      S_MEM: bus.MemReq = 1'b1;
      S_FILL: begin
        bus.TagWrite  = 1'b1;
        bus.DataWrite = 1'b1;
        bus.CpuAck    = 1'b1;
        bus.CpuRdata  = fill_data;
      end
      default: ;
    endcase
  end

  assign bus.TagAddr  = ram_idx;
  assign bus.DataAddr = ram_idx;
  assign bus.TagIn    = tag_q;
  assign bus.DataIn   = fill_data;
  assign bus.MemAddr  = {tag_q, idx_q, {OFFSET_W{1'b0}}};
  assign bus.HitCnt   = hit_cnt;
  assign bus.MissCnt  = miss_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid    <= '0;
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
      rdata_q  <= '0;
    end else begin
      if (state == S_IDLE && bus.Flush) valid <= '0;
      if (state == S_FILL)              valid[idx_q] <= 1'b1;
      if (state == S_LOOKUP && hit && hit_cnt != 16'hFFFF)
        hit_cnt <= hit_cnt + 16'd1;
      if (state == S_LOOKUP && !hit && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
      if (bus.CpuAck) rdata_q <= bus.CpuRdata;
    end
  end

  // Request fields and the refill word need no reset: they are only consumed after being written.
  always_ff @(posedge Clk) begin
    if (accept) begin
      tag_q <= cpu_tag;
      idx_q <= cpu_idx;
    end
    if (state == S_MEM && bus.MemAck) fill_data <= bus.MemRdata;
  end
endmodule
`default_nettype wire
